// File: rtl/priority_encoder_pipe_pkg.sv
// priority_encoder_pipe_pkg: mode constants and index-width helper shared by the encoder files.
package priority_encoder_pipe_pkg;
    localparam int LSB_MODE = 1;
    localparam int MSB_MODE = 0;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/priority_encoder_pipe_if.sv
// priority_encoder_pipe_if: input and result handshake bundle for the priority encoder.
interface priority_encoder_pipe_if #(
    parameter int INPUT_W  = 8,
    parameter int OUTPUT_W = 3
);
    logic                i_valid;
    logic [INPUT_W-1:0]  i;
    logic                i_ready;
    logic                o_valid;
    logic [OUTPUT_W-1:0] o;
    logic                o_zero;
    logic                o_multi;
    logic                o_ready;
    modport master (output i_valid, i, o_ready, input i_ready, o_valid, o, o_zero, o_multi);
    modport slave  (input i_valid, i, o_ready, output i_ready, o_valid, o, o_zero, o_multi);
endinterface

// File: rtl/priority_encoder_pipe_group_encoder.sv
// group_encoder: combinational local priority encode of one GROUP_W-bit slice.
module group_encoder
    import priority_encoder_pipe_pkg::*;
#(
    parameter int GROUP_W   = 4,
    parameter int LSB_FIRST = LSB_MODE,
    localparam int LW       = idx_w(GROUP_W)
) (
    input  logic [GROUP_W-1:0] bits,
    output logic [LW-1:0]      idx,
    output logic               any,
    output logic               multi
);
    assign any   = |bits;
    assign multi = (bits & (bits - GROUP_W'(1))) != '0;
    // Scan toward the winning end so the last hit is the winner.
    always_comb begin
        idx = '0;
        for (int k = 0; k < GROUP_W; k++)
            if (bits[LSB_FIRST == LSB_MODE ? GROUP_W - 1 - k : k])
                idx = LW'(LSB_FIRST == LSB_MODE ? GROUP_W - 1 - k : k);
    end
endmodule

// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe: two-stage pipelined priority encoder with one-hot error counting.
module priority_encoder_pipe
    import priority_encoder_pipe_pkg::*;
#(
    parameter int INPUT_W   = 8,
    parameter int OUTPUT_W  = idx_w(INPUT_W),
    parameter int GROUP_W   = 4,
    parameter int LSB_FIRST = LSB_MODE,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_encoder_pipe_if.slave bus,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int NG = INPUT_W / GROUP_W;
    localparam int LW = idx_w(GROUP_W);
    localparam int GW = idx_w(NG);
    logic [NG-1:0]         g_any, g_multi, s1_any, s1_multi;
    logic [NG-1:0][LW-1:0] g_idx, s1_idx;
    logic                  s1_valid, s2_valid, s1_load, s2_load, accept, in_err, s1_multi_all;
    logic [GW-1:0]         win_g;
    logic [LW-1:0]         win_l;
    int                    j;

    for (genvar g = 0; g < NG; g++) begin : gen_grp
        group_encoder #(.GROUP_W(GROUP_W), .LSB_FIRST(LSB_FIRST)) u_grp (
            .bits (bus.i[g*GROUP_W +: GROUP_W]),
            .idx  (g_idx[g]),
            .any  (g_any[g]),
            .multi(g_multi[g])
        );
    end

    assign s2_load     = ~s2_valid | bus.o_ready;
    assign s1_load     = ~s1_valid | s2_load;
    assign bus.i_ready = s1_load;
    assign bus.o_valid = s2_valid;
    assign accept      = bus.i_valid & s1_load;
    // Multi-hot spans groups: any group multi, or more than one group hit.
    assign in_err       = ~|g_any | |g_multi | ((g_any & (g_any - NG'(1))) != '0);
    assign s1_multi_all = |s1_multi | ((s1_any & (s1_any - NG'(1))) != '0);

    always_comb begin
        win_g = '0;
        win_l = '0;
        j     = 0;
        for (int k = 0; k < NG; k++) begin
            j = (LSB_FIRST == LSB_MODE) ? NG - 1 - k : k;
            if (s1_any[j]) begin
                win_g = GW'(j);
                win_l = s1_idx[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_any   <= '0;
            s1_multi <= '0;
            s1_idx   <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.i_valid;
            s1_any   <= g_any;
            s1_multi <= g_multi;
            s1_idx   <= g_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            bus.o       <= '0;
            bus.o_zero  <= 1'b0;
            bus.o_multi <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.o       <= OUTPUT_W'({win_g, win_l});
                bus.o_zero  <= ~|s1_any;
                bus.o_multi <= s1_multi_all;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (accept && in_err && err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
    end
endmodule

// File: doc/priority_encoder_pipe.md
PRIORITY_ENCODER_PIPE -- requirements
Module: priority_encoder_pipe

Interface
REQ-001 SHALL have parameter INPUT_W, default 8, meaning input vector width (>=2, multiple of GROUP_W).
REQ-002 SHALL have parameter OUTPUT_W, default 3, meaning index width, equal to ceil(log2(INPUT_W)).
REQ-003 SHALL have parameter GROUP_W, default 4, meaning bits per stage-1 group (power of two).
REQ-004 SHALL have parameter LSB_FIRST, default 1, meaning 1 = lowest set bit wins, 0 = highest set bit wins.
REQ-005 SHALL have parameter CNT_W, default 8, meaning error-counter width.
REQ-006 clk  input  1  rising-edge clock; the block has one clock.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 i  input  INPUT_W  vector to encode.
REQ-010 i_ready  output  1  block accepts a beat this cycle.
REQ-011 o_valid  output  1  result valid.
REQ-012 o  output  OUTPUT_W  encoded index of winning bit.
REQ-013 o_zero  output  1  input had no bit set.
REQ-014 o_multi  output  1  input had more than one bit set (not one-hot).
REQ-015 o_ready  input  1  downstream accepts result.
REQ-016 err_clr  input  1  synchronous clear of err_cnt.
REQ-017 err_cnt  output  CNT_W  count of accepted non-one-hot beats (zero or multi).

Function
REQ-018 A beat SHALL transfer in when i_valid and i_ready are both 1 at a rising edge; out when o_valid and o_ready are both 1.
REQ-019 Pipeline SHALL be two register stages: S1 holds per-group any-set, group-local index, group-local multi flags; S2 holds o, o_zero, o_multi.
REQ-020 Latency SHALL be exactly 2 cycles from input handshake to o_valid with o_ready held 1; throughput one beat per cycle.
REQ-021 Each stage SHALL load when empty or when the stage after it is draining; i_ready SHALL equal (S1 empty) or (S2 empty) or o_ready, with no combinational path from i_valid to i_ready.
REQ-022 While o_valid=1 and o_ready=0, o, o_zero, o_multi SHALL hold stable.
REQ-023 o SHALL be the index of the lowest set bit when LSB_FIRST=1, highest set bit when LSB_FIRST=0.
REQ-024 If i is all zero: o_zero=1, o=0, o_multi=0.
REQ-025 o_multi SHALL be 1 when two or more bits are set, including bits in different groups.
REQ-026 err_cnt SHALL increment by one on each accepted input beat with zero or multi-hot data; it SHALL saturate at all-ones.
REQ-027 err_clr coincident with an error beat SHALL clear to 0; the clear wins and that beat is not counted.
REQ-028 Group index width SHALL be log2(GROUP_W); final o = group number concatenated with local index, zero-extended to OUTPUT_W.

Reset
REQ-029 rst_n low SHALL asynchronously clear both stage-valid flags, o, o_zero, o_multi and err_cnt to 0; i_ready SHALL read 1 during and after reset.
REQ-030 Reset mid-operation SHALL discard in-flight beats; no o_valid until a new beat is accepted after release.

Structure
REQ-031 A shared package SHALL hold the LSB_FIRST mode constants and an OUTPUT_W width-helper function.
REQ-032 One sub-module, group_encoder (combinational, GROUP_W in, local index, any, multi out), SHALL be instantiated INPUT_W/GROUP_W times.

Verification (INPUT_W=8, GROUP_W=4, LSB_FIRST=1 unless stated)
REQ-033 Walking one-hot 0x01..0x80, o_ready=1 -> o = 0..7 two cycles after each beat, o_multi=0, o_zero=0, err_cnt=0.
REQ-034 i=0x00 then 0x28 -> first result o_zero=1, o=0; second o=3, o_multi=1; err_cnt=2. Same with LSB_FIRST=0 -> second o=5.
REQ-035 Back-to-back 4 beats with o_ready low for 3 cycles mid-stream -> i_ready falls after 2 beats queued, outputs stable, no beat lost or duplicated, order preserved.
REQ-036 260 consecutive 0xFF beats -> err_cnt saturates at 255; err_clr pulse with a 0xFF beat -> err_cnt=0.
REQ-037 rst_n asserted with two beats in flight -> o_valid=0 and err_cnt=0 immediately, i_ready=1, no stale output after release.
